// File: rtl/lcd_timing_pkg.sv
// Default panel timing for the 480x272 RGB panel set and a helper that sums
// one axis of timing into its total period.
package lcd_timing_pkg;

    localparam int H_ACTIVE_DEF = 480;
    localparam int H_FP_DEF     = 2;
    localparam int H_SYNC_DEF   = 41;
    localparam int H_BP_DEF     = 2;

    localparam int V_ACTIVE_DEF = 272;
    localparam int V_FP_DEF     = 2;
    localparam int V_SYNC_DEF   = 10;
    localparam int V_BP_DEF     = 2;

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button -> two-flop synchroniser -> stability down-counter.
// A level is accepted after DB_CYCLES consecutive equal samples; an accepted
// high-to-low transition produces a single-cycle press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 360000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int            CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    // The DB_CYCLES-th consecutive differing sample is the one that lands on
    // terminal count.
    assign accept = (sync[1] != stable) && (cnt == '0);

    // Synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    // Stability timer, accepted level and press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= RELOAD;
            press  <= 1'b0;
        end else begin
            press <= accept && !sync[1];
            if (sync[1] == stable) begin
                cnt <= RELOAD;
            end else if (accept) begin
                stable <= sync[1];
                cnt    <= RELOAD;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD video timing generator: h/v counters with registered sync/DE decode,
// a frame-start pulse, and an animation index whose frame divider is trimmed
// at run time by two debounced buttons.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_POL    = 1'b0,
    parameter int ANIM_FRAMES = 10,
    parameter int DIV_MIN     = 1,
    parameter int DIV_MAX     = 15,
    parameter int DIV_INIT    = 4,
    parameter int DB_CYCLES   = 360000,
    localparam int H_TOTAL    = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL    = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW         = $clog2(H_TOTAL),
    localparam int YW         = $clog2(V_TOTAL),
    localparam int AW         = $clog2(ANIM_FRAMES),
    localparam int DW         = $clog2(DIV_MAX + 1)
) (
    input  logic          i_clk,
    input  logic          i_res_n,
    input  logic          i_pix_en,
    input  logic          i_btn_a,
    input  logic          i_btn_b,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_frame_start,
    output logic [AW-1:0] o_anim_idx,
    output logic [DW-1:0] o_speed
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW-1:0] A_LAST   = AW'(ANIM_FRAMES - 1);
    localparam logic [DW-1:0] SPD_MIN  = DW'(DIV_MIN);
    localparam logic [DW-1:0] SPD_MAX  = DW'(DIV_MAX);

    logic [XW-1:0] h, h_nxt;
    logic [YW-1:0] v, v_nxt;
    logic [DW-1:0] cnt;
    logic          frame_hit;
    logic          press_a, press_b;

    // Next position; outputs are decoded from it so they describe the
    // position the counters move to on the same edge.
    always_comb begin
        h_nxt = h + XW'(1);
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + YW'(1);
        end
    end

    assign frame_hit = i_pix_en && (h_nxt == '0) && (v_nxt == '0);

    // Position counters and registered sync/DE/coordinate outputs. Reset
    // parks the counters on the last position so the first enable lands on
    // (0,0).
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            h       <= H_LAST;
            v       <= V_LAST;
            o_x     <= '0;
            o_y     <= '0;
            o_de    <= 1'b0;
            o_hsync <= ~SYNC_POL;
            o_vsync <= ~SYNC_POL;
        end else if (i_pix_en) begin
            h       <= h_nxt;
            v       <= v_nxt;
            o_x     <= h_nxt;
            o_y     <= v_nxt;
            o_de    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            o_hsync <= (h_nxt >= HS_START && h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
            o_vsync <= (v_nxt >= VS_START && v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Frame-start pulse; cleared on every edge that does not enter (0,0), so
    // it lasts one clock even with the enable held high.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= frame_hit;
        end
    end

    // Frame divider and animation index. The >= compare lets a speed drop
    // below the current count take effect at the very next frame start.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            cnt        <= '0;
            o_anim_idx <= '0;
        end else if (frame_hit) begin
            if (cnt >= o_speed - DW'(1)) begin
                cnt        <= '0;
                o_anim_idx <= (o_anim_idx == A_LAST) ? '0 : o_anim_idx + AW'(1);
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

    // Speed divider: A shortens, B lengthens, both at once cancel.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_speed <= DW'(DIV_INIT);
        end else if (press_a && !press_b && o_speed > SPD_MIN) begin
            o_speed <= o_speed - DW'(1);
        end else if (press_b && !press_a && o_speed < SPD_MAX) begin
            o_speed <= o_speed + DW'(1);
        end
    end

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
        .clk   (i_clk),
        .rst_n (i_res_n),
        .btn   (i_btn_a),
        .press (press_a)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
        .clk   (i_clk),
        .rst_n (i_res_n),
        .btn   (i_btn_b),
        .press (press_b)
    );

endmodule
